completion_collector: RTL
=========================

// Module: completion_collector
// PURPOSE
//  Receiving end of the completion path: accepts completion packets (command + write-data
//  beats) on the inner interface, keeps only those addressed to ThisID, and buffers each
//  beat in a FWFT FIFO read by the host-side status logic. Foreign packets are drained.
// PARAMETERS
//  AddressWidth        32  width of iSrcAddress (accepted, not stored)
//  DataWidth           32  completion data word width
//  InnerIFLengthWidth  16  width of iSrcLength (beat count)
//  ThisID              1   target ID this collector owns
//  FifoDepthLog2       4   log2 of FIFO entries (16)
//  CplOpcode           6'b000001  opcode accepted when CPL_OPCODE_CHECK_EN is defined
// PORTS
//  iClock          in   1       clock
//  iReset          in   1       async reset, active-high
//  iSrcOpcode      in   6       command opcode
//  iSrcTargetID    in   5       destination ID
//  iSrcSourceID    in   5       originating ID, stored with every beat
//  iSrcAddress     in   AW      unused beyond handshake
//  iSrcLength      in   ILW     beats in packet; 0 treated as 1
//  iSrcCmdValid    in   1       command valid
//  oSrcCmdReady    out  1       command ready
//  iSrcWriteData   in   DW      data beat
//  iSrcWriteValid  in   1       beat valid
//  iSrcWriteLast   in   1       final beat marker
//  oSrcWriteReady  out  1       beat ready
//  oCplData        out  DW      FIFO head data
//  oCplSourceID    out  5       FIFO head source ID
//  oCplLast        out  1       FIFO head is final beat of its packet
//  oCplValid       out  1       FIFO not empty
//  iCplReady       in   1       pop FIFO head
//  oCplCount       out  FL2+1   FIFO occupancy
//  oLengthError    out  1       one-cycle pulse on length/last mismatch
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, FIFO empty, counter 0; oCplValid 0, oCplCount 0,
//    oSrcWriteReady 0, oLengthError 0, oSrcCmdReady 1 once state is IDLE. Reset mid-packet
//    discards the packet and flushes the FIFO; remaining beats upstream are not drained.
//  - FSM IDLE/DATA/DROP. oSrcCmdReady = (state==IDLE). Cmd handshake = valid & ready.
//  - IDLE: on handshake latch SourceID, load counter = (Length==0 ? 1 : Length);
//    TargetID==ThisID -> DATA, else -> DROP.
//  - DATA: oSrcWriteReady = !full (registered occupancy). Each beat handshake pushes
//    {last_flag, SourceID, data}; counter decrements.
//  - DROP: oSrcWriteReady = 1; beats discarded; counter decrements; nothing pushed.
//  - Packet ends on the beat where counter==1 OR iSrcWriteLast==1 (first to occur) -> IDLE;
//    that beat pushed with last_flag=1 (DATA only). If exactly one of (counter==1, Last)
//    holds on the ending beat, oLengthError pulses next cycle (DATA and DROP).
//  - No command accepted before the current packet ends (single outstanding packet).
//  - FIFO: FWFT, 2^FifoDepthLog2 entries, pointers wrap mod depth, count is FL2+1 bits.
//    oCplValid = count!=0; pop on oCplValid & iCplReady; pop while empty ignored.
//    Push and pop same cycle: count unchanged, both applied. Full blocks push via ready.
//  - Latency: beat accepted in cycle N visible on oCpl* in cycle N+1.
//  - Cmd and first beat may not share a cycle: oSrcWriteReady is 0 in IDLE.
// CONFIGURATION
//  CPL_OPCODE_CHECK_EN defined: a command with iSrcOpcode != CplOpcode goes to DROP even
//  if TargetID matches. Undefined: opcode ignored; only TargetID selects DATA vs DROP.
// TESTING
//  1 Cmd Tgt=1 Src=3 Len=2, beats 0xA5A5A5A5, 0x5A5A5A5A(Last) -> two entries Src=3,
//    Last=0 then 1; oCplCount 2; no oLengthError.
//  2 Cmd Tgt=7 Len=3, 3 beats -> all accepted with ready=1, FIFO stays empty, IDLE after.
//  3 Hold iCplReady=0, send 16 one-beat packets then a 17th -> oSrcWriteReady=0 on 17th
//    beat until one pop; oCplCount never exceeds 16.
//  4 Len=4 with Last on beat 2 -> packet ends at beat 2, entry Last=1, oLengthError pulse;
//    Len=1 without Last -> ends after 1 beat, pulse.
//  5 Count=5, push and pop same cycle -> count stays 5, head advances by one.
//  6 Assert iReset during beat 2 of Len=4 DATA packet -> FIFO empty, outputs at reset
//    values; new Tgt=1 Len=1 packet afterwards collected normally.

Source files
------------

// File: rtl/completion_collector.sv
// completion_collector: filters completion packets by ThisID and queues their beats in a FWFT FIFO.
// Optional build macro CPL_OPCODE_CHECK_EN also requires iSrcOpcode == CplOpcode to collect a packet.
module completion_collector #(
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int InnerIFLengthWidth = 16,
  parameter int ThisID = 1,
  parameter int FifoDepthLog2 = 4,
  parameter logic [5:0] CplOpcode = 6'b000001
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [5:0]                    iSrcOpcode,
  input  logic [4:0]                    iSrcTargetID,
  input  logic [4:0]                    iSrcSourceID,
  input  logic [AddressWidth-1:0]       iSrcAddress,
  input  logic [InnerIFLengthWidth-1:0] iSrcLength,
  input  logic                          iSrcCmdValid,
  output logic                          oSrcCmdReady,
  input  logic [DataWidth-1:0]          iSrcWriteData,
  input  logic                          iSrcWriteValid,
  input  logic                          iSrcWriteLast,
  output logic                          oSrcWriteReady,
  output logic [DataWidth-1:0]          oCplData,
  output logic [4:0]                    oCplSourceID,
  output logic                          oCplLast,
  output logic                          oCplValid,
  input  logic                          iCplReady,
  output logic [FifoDepthLog2:0]        oCplCount,
  output logic                          oLengthError
);
  localparam int Depth = 1 << FifoDepthLog2;
  localparam int EntryWidth = DataWidth + 6;
  typedef enum logic [1:0] {IDLE, DATA, DROP} stateType;
  stateType state;
  logic [InnerIFLengthWidth-1:0] beatCounter;
  logic [4:0] sourceId;
  logic [EntryWidth-1:0] fifoMem [Depth];
  logic [FifoDepthLog2-1:0] wrPtr, rdPtr;
  logic [FifoDepthLog2:0] count;
  logic fifoFull, beatFire, lastCount, endFlag, endBeat, push, pop, targetHit;
  logic unusedBits;
  assign unusedBits = ^{iSrcAddress, iSrcOpcode};
`ifdef CPL_OPCODE_CHECK_EN
  assign targetHit = (iSrcTargetID == 5'(ThisID)) && (iSrcOpcode == CplOpcode);
`else
  assign targetHit = iSrcTargetID == 5'(ThisID);
`endif
  assign fifoFull = count == (FifoDepthLog2+1)'(Depth);
  assign oSrcCmdReady = state == IDLE;
  assign oSrcWriteReady = (state == DATA) ? !fifoFull : (state == DROP);
  assign beatFire = iSrcWriteValid && oSrcWriteReady;
  assign lastCount = beatCounter == InnerIFLengthWidth'(1);
  assign endFlag = lastCount || iSrcWriteLast;
  assign endBeat = beatFire && endFlag;
  assign push = beatFire && (state == DATA);
  assign pop = oCplValid && iCplReady;
  assign oCplValid = count != '0;
  assign oCplCount = count;
  assign {oCplLast, oCplSourceID, oCplData} = fifoMem[rdPtr];
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state <= IDLE;
      beatCounter <= '0;
      sourceId <= '0;
      oLengthError <= 1'b0;
    end else begin
      // a mismatch is only flagged when exactly one of the two end conditions caused the end
      oLengthError <= endBeat && (lastCount != iSrcWriteLast);
      if (state == IDLE && iSrcCmdValid) begin
        sourceId <= iSrcSourceID;
        beatCounter <= (iSrcLength == '0) ? InnerIFLengthWidth'(1) : iSrcLength;
        state <= targetHit ? DATA : DROP;
      end else if (beatFire) begin
        beatCounter <= beatCounter - InnerIFLengthWidth'(1);
        if (endFlag) state <= IDLE;
      end
    end
  end
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + (FifoDepthLog2+1)'(push) - (FifoDepthLog2+1)'(pop);
    end
  end
  always_ff @(posedge iClock) begin
    if (push) fifoMem[wrPtr] <= {endFlag, sourceId, iSrcWriteData};
  end
endmodule
